// File: rtl/led_matrix_scanner_if.sv
// Bus between the game/display-select logic and the 8x8 RGB LED matrix scanner.
// Handshake: the game side raises frame_done to request a front/back swap.
// busy high means a swap is pending; pixel writes and back-buffer clears are
// dropped while it is high. busy falls on the column wrap that performs the
// swap. A frame_done seen in the wrap cycle itself swaps immediately and busy
// never rises.
interface led_matrix_scanner_if;
    logic       pix_we;
    logic [2:0] pix_x;
    logic [2:0] pix_y;
    logic [2:0] pix_rgb;
    logic       clr_back;
    logic       frame_done;
    logic       busy;
    logic       frame_start;
    logic [7:0] position_R;
    logic [7:0] position_G;
    logic [7:0] position_B;
    logic [2:0] S;
    logic [0:0] dbg_state;  // swap FSM state: 0 idle, 1 swap pending

    modport master (
        output pix_we, pix_x, pix_y, pix_rgb, clr_back, frame_done,
        input  busy, frame_start, position_R, position_G, position_B, S, dbg_state
    );

    modport slave (
        input  pix_we, pix_x, pix_y, pix_rgb, clr_back, frame_done,
        output busy, frame_start, position_R, position_G, position_B, S, dbg_state
    );
endinterface

// File: rtl/led_matrix_scanner.sv
// Double-buffered 8x8 RGB frame store and column scanner.
// Game logic writes the back buffer and requests a swap; the swap lands on the
// next column wrap (7->0) so a frame is never torn. The front buffer is only
// ever read. Row drives are active-low and registered (one cycle behind col).
// Optional feature: define SCAN_BLANK_EN to blank the row drives for the first
// BLANK_CYC cycles of every column (anti-ghosting).
module led_matrix_scanner #(
    parameter int unsigned SCAN_DIV  = 2500,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic                 CLK,
    input  logic                 Clear,
    led_matrix_scanner_if.slave  bus
);

`ifdef SCAN_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    localparam logic [15:0] DIV_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] BLANK_LIM = 16'(BLANK_CYC);

    if (SCAN_DIV < 1 || SCAN_DIV > 65535) begin : g_bad_div
        $error("SCAN_DIV must be in 1..65535");
    end
    if (BLANK_EN && (BLANK_CYC >= SCAN_DIV)) begin : g_bad_blank
        $error("BLANK_CYC must be smaller than SCAN_DIV");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } swap_state_e;

    // Scan position and swap control
    logic [15:0]      div_cnt_q, div_cnt_d;
    logic [2:0]       col_q, col_d;
    logic             sel_q, sel_d;      // 0: buf0 is front, 1: buf1 is front
    swap_state_e      state_q, state_d;

    // Frame buffers, indexed by {x, y}; each entry is {R, G, B}
    logic [63:0][2:0] buf0_q;
    logic [63:0][2:0] buf1_q;

    // Registered matrix drive
    logic [2:0]       s_q;
    logic [7:0]       pos_r_q, pos_r_d;
    logic [7:0]       pos_g_q, pos_g_d;
    logic [7:0]       pos_b_q, pos_b_d;
    logic             fs_q;

    logic             tick;
    logic             wrap;
    logic             swap;
    logic             wr_en;
    logic             clr_en;
    logic             blank;
    logic [2:0]       pix;
    logic [5:0]       waddr;

    assign waddr = {bus.pix_x, bus.pix_y};

    // Prescaler, column counter and swap FSM next state.
    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        wrap      = tick && (col_q == 3'd7);
        div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
        col_d     = tick ? col_q + 3'd1 : col_q;
        state_d   = state_q;
        swap      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.frame_done) begin
                    if (wrap) swap = 1'b1;
                    else      state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (wrap) begin
                    swap    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        sel_d  = swap ? ~sel_q : sel_q;
        wr_en  = (state_q == ST_IDLE) && bus.pix_we;
        clr_en = (state_q == ST_IDLE) && bus.clr_back;
    end

    // Row drive for the current column of the front buffer, with optional blanking.
    always_comb begin
        pos_r_d = 8'hFF;
        pos_g_d = 8'hFF;
        pos_b_d = 8'hFF;
        pix     = 3'b000;
        blank   = BLANK_EN && (div_cnt_q < BLANK_LIM);
        for (int y = 0; y < 8; y++) begin
            pix = sel_q ? buf1_q[{col_q, 3'(y)}] : buf0_q[{col_q, 3'(y)}];
            if (!blank) begin
                pos_r_d[y] = ~pix[2];
                pos_g_d[y] = ~pix[1];
                pos_b_d[y] = ~pix[0];
            end
        end
    end

    // Scan counters, buffer select and swap state registers.
    always_ff @(posedge CLK) begin
        if (!Clear) begin
            div_cnt_q <= 16'd0;
            col_q     <= 3'd0;
            sel_q     <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            div_cnt_q <= div_cnt_d;
            col_q     <= col_d;
            sel_q     <= sel_d;
            state_q   <= state_d;
        end
    end

    // Back-buffer clear then pixel write; the write lands after the clear so it survives.
    always_ff @(posedge CLK) begin
        if (!Clear) begin
            buf0_q <= '0;
            buf1_q <= '0;
        end else begin
            if (clr_en) begin
                if (sel_q) buf0_q <= '0;
                else       buf1_q <= '0;
            end
            if (wr_en) begin
                if (sel_q) buf0_q[waddr] <= bus.pix_rgb;
                else       buf1_q[waddr] <= bus.pix_rgb;
            end
        end
    end

    // Matrix pins, registered every cycle from col and the front buffer.
    always_ff @(posedge CLK) begin
        if (!Clear) begin
            s_q     <= 3'd0;
            pos_r_q <= 8'hFF;
            pos_g_q <= 8'hFF;
            pos_b_q <= 8'hFF;
            fs_q    <= 1'b0;
        end else begin
            s_q     <= col_q;
            pos_r_q <= pos_r_d;
            pos_g_q <= pos_g_d;
            pos_b_q <= pos_b_d;
            fs_q    <= wrap;
        end
    end

    assign bus.S           = s_q;
    assign bus.position_R  = pos_r_q;
    assign bus.position_G  = pos_g_q;
    assign bus.position_B  = pos_b_q;
    assign bus.frame_start = fs_q;
    assign bus.busy        = (state_q == ST_PEND);
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner (SCAN_DIV=4, blanking off).
// A frame-level model tracks front/back pixel arrays and the pending swap;
// on every column wrap it queues the frame that should be scanned next.
// The monitor pops a frame on each frame_start pulse and checks all eight
// columns as they appear, checks busy every cycle, and checks the pins
// after every reset cycle.
module tb_led_matrix_scanner;
    localparam int DIV   = 4;
    localparam int FRAME = 8 * DIV;

    logic CLK   = 1'b0;
    logic Clear = 1'b0;

    led_matrix_scanner_if bus();

    led_matrix_scanner #(.SCAN_DIV(DIV), .BLANK_CYC(2)) dut (
        .CLK   (CLK),
        .Clear (Clear),
        .bus   (bus)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Scoreboard state
    logic [191:0] exp_q[$];
    int           total = 0;
    int           bad   = 0;
    bit           done  = 1'b0;

    // Reference model state
    logic [2:0]   m_front[64];
    logic [2:0]   m_back[64];
    logic [2:0]   m_tmp;
    logic [191:0] m_frame;
    bit           m_pend = 1'b0;
    bit           m_rst  = 1'b0;
    bit           m_wrap = 1'b0;
    int           m_cyc  = 0;

    // Reference model: evaluated on each rising edge with the inputs the bench drove.
    initial begin
        for (int i = 0; i < 64; i++) begin
            m_front[i] = '0;
            m_back[i]  = '0;
        end
        forever begin
            @(posedge CLK);
            if (!Clear) begin
                for (int i = 0; i < 64; i++) begin
                    m_front[i] = '0;
                    m_back[i]  = '0;
                end
                m_pend = 1'b0;
                m_cyc  = 0;
                m_rst  = 1'b1;
                exp_q.delete();
            end else begin
                m_rst  = 1'b0;
                m_wrap = (m_cyc % FRAME) == FRAME - 1;
                if (!m_pend) begin
                    if (bus.clr_back)
                        for (int i = 0; i < 64; i++) m_back[i] = '0;
                    if (bus.pix_we)
                        m_back[int'(bus.pix_x) * 8 + int'(bus.pix_y)] = bus.pix_rgb;
                end
                if (m_wrap && (m_pend || bus.frame_done)) begin
                    for (int i = 0; i < 64; i++) begin
                        m_tmp      = m_front[i];
                        m_front[i] = m_back[i];
                        m_back[i]  = m_tmp;
                    end
                    m_pend = 1'b0;
                end else if (bus.frame_done) begin
                    m_pend = 1'b1;
                end
                if (m_wrap) begin
                    for (int i = 0; i < 64; i++) m_frame[i*3 +: 3] = m_front[i];
                    exp_q.push_back(m_frame);
                end
                m_cyc++;
            end
        end
    end

    // Monitor: all comparisons, sampled on the falling edge.
    initial begin
        logic [191:0] cur;
        logic [27:0]  got, want;
        logic [7:0]   er, eg, eb;
        int           mon_k;
        int           mon_wait;
        mon_k    = -1;
        mon_wait = 0;
        cur      = '0;
        forever begin
            @(negedge CLK);
            if (done) begin
                total++;
                if (exp_q.size() > 1) begin
                    bad++;
                    $display("FAIL queue_drain: %0d frames left unchecked, required at most 1", exp_q.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            total++;
            if (bus.busy !== m_pend) begin
                bad++;
                $display("FAIL busy: got %b want %b at model cycle %0d", bus.busy, m_pend, m_cyc);
            end
            if (m_rst) begin
                mon_k = -1;
                total++;
                got  = {bus.frame_start, bus.S, bus.position_R, bus.position_G, bus.position_B};
                want = {1'b0, 3'd0, 8'hFF, 8'hFF, 8'hFF};
                if (got !== want) begin
                    bad++;
                    $display("FAIL reset_pins: got %h want %h", got, want);
                end
            end else begin
                if (mon_k >= 0) begin
                    mon_wait--;
                    if (mon_wait == 0) begin
                        for (int y = 0; y < 8; y++) begin
                            er[y] = ~cur[(mon_k * 8 + y) * 3 + 2];
                            eg[y] = ~cur[(mon_k * 8 + y) * 3 + 1];
                            eb[y] = ~cur[(mon_k * 8 + y) * 3 + 0];
                        end
                        got  = {bus.frame_start, bus.S, bus.position_R, bus.position_G, bus.position_B};
                        want = {1'b0, 3'(mon_k), er, eg, eb};
                        total++;
                        if (got !== want) begin
                            bad++;
                            $display("FAIL col%0d {fs,S,R,G,B}: got %h want %h", mon_k, got, want);
                        end
                        mon_k++;
                        if (mon_k == 8) mon_k = -1;
                        else            mon_wait = DIV;
                    end
                end
                if (bus.frame_start) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL frame_pop: frame_start high, required no pulse (no frame expected)");
                        mon_k = -1;
                    end else begin
                        cur      = exp_q.pop_front();
                        mon_k    = 0;
                        mon_wait = 1;
                    end
                end
            end
        end
    end

    // Driver tasks (called on a falling edge, return on a falling edge)
    task automatic drive_idle();
        bus.pix_we     = 1'b0;
        bus.clr_back   = 1'b0;
        bus.frame_done = 1'b0;
    endtask

    task automatic write_pix(input logic [2:0] x, input logic [2:0] y,
                             input logic [2:0] rgb, input bit clr);
        bus.pix_we   = 1'b1;
        bus.pix_x    = x;
        bus.pix_y    = y;
        bus.pix_rgb  = rgb;
        bus.clr_back = clr;
        @(negedge CLK);
        drive_idle();
    endtask

    task automatic wait_phase(input int p);
        int n;
        n = 0;
        while ((m_cyc % FRAME) != p && n < 4 * FRAME) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic pulse_fd();
        bus.frame_done = 1'b1;
        @(negedge CLK);
        bus.frame_done = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        repeat (n * FRAME) @(negedge CLK);
    endtask

    // Stimulus
    initial begin
        bus.pix_x   = 3'd0;
        bus.pix_y   = 3'd0;
        bus.pix_rgb = 3'd0;
        drive_idle();
        Clear = 1'b0;
        repeat (2) @(negedge CLK);
        Clear = 1'b1;

        // Single red pixel at column 3, row 5, then swap.
        write_pix(3'd3, 3'd5, 3'b100, 1'b0);
        wait_phase(2);
        pulse_fd();
        wait_frames(2);

        // Swap requested, then a write while busy that must be dropped.
        wait_phase(2);
        pulse_fd();
        write_pix(3'd0, 3'd0, 3'b111, 1'b0);
        wait_frames(2);
        wait_phase(2);
        pulse_fd();
        wait_frames(2);

        // Clear and write in the same cycle, then swap.
        write_pix(3'd6, 3'd6, 3'b011, 1'b0);
        write_pix(3'd7, 3'd0, 3'b010, 1'b1);
        wait_phase(2);
        pulse_fd();
        wait_frames(2);

        // frame_done exactly in the wrap cycle: swap without busy.
        write_pix(3'd1, 3'd2, 3'b001, 1'b0);
        wait_phase(FRAME - 1);
        pulse_fd();
        wait_frames(2);

        // Randomized traffic.
        for (int c = 0; c < 25 * FRAME; c++) begin
            bus.pix_we     = ($urandom_range(0, 1) == 1);
            bus.pix_x      = 3'($urandom_range(0, 7));
            bus.pix_y      = 3'($urandom_range(0, 7));
            bus.pix_rgb    = 3'($urandom_range(0, 7));
            bus.clr_back   = ($urandom_range(0, 39) == 0);
            bus.frame_done = ($urandom_range(0, 29) == 0);
            @(negedge CLK);
        end
        drive_idle();

        // Make sure something is lit, then reset in the middle of column 5.
        write_pix(3'd5, 3'd4, 3'b111, 1'b0);
        wait_phase(2);
        pulse_fd();
        wait_frames(2);
        wait_phase(5 * DIV + 1);
        Clear = 1'b0;
        @(negedge CLK);
        Clear = 1'b1;
        wait_frames(3);

        done = 1'b1;
    end

endmodule
